friscv_axil_apb_bridge: RTL and testbench

- Parametrised AXI4-lite slave to APB-style master bridge, fanning out to NSLV low-speed peripherals (GPIO, UART, CLINT, future cores).
- Decodes each request against a per-slave address window. Out-of-window requests are answered with DECERR and no peripheral access.
- Adds three things over the fixed three-slave converter:
  - read/write round-robin arbitration;
  - correct lane selection on both channels;
  - a per-access timeout that returns SLVERR.

---
 rtl/friscv_axil_apb_bridge.sv | 240 ++++++++++++++++++++++++
 tb/tb_friscv_axil_apb_bridge.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/friscv_axil_apb_bridge.sv
// AXI4-lite slave to APB-style master bridge with address-window decode,
// read/write round-robin arbitration, lane selection and an access timeout.
module friscv_axil_apb_bridge #(
  parameter int ADDRW = 16,
  parameter int DATAW = 128,
  parameter int IDW = 16,
  parameter int XLEN = 32,
  parameter int NSLV = 4,
  parameter logic [NSLV*ADDRW-1:0] SLV_ADDR = {16'h0030, 16'h0020, 16'h0010, 16'h0000},
  parameter logic [NSLV*ADDRW-1:0] SLV_SIZE = {16'h0010, 16'h0010, 16'h0010, 16'h0010},
  parameter int TIMEOUT = 256
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic                  slv_awvalid,
  output logic                  slv_awready,
  input  logic [ADDRW-1:0]      slv_awaddr,
  input  logic [2:0]            slv_awprot,
  input  logic [IDW-1:0]        slv_awid,
  input  logic                  slv_wvalid,
  output logic                  slv_wready,
  input  logic [DATAW-1:0]      slv_wdata,
  input  logic [DATAW/8-1:0]    slv_wstrb,
  output logic                  slv_bvalid,
  input  logic                  slv_bready,
  output logic [1:0]            slv_bresp,
  output logic [IDW-1:0]        slv_bid,
  input  logic                  slv_arvalid,
  output logic                  slv_arready,
  input  logic [ADDRW-1:0]      slv_araddr,
  input  logic [2:0]            slv_arprot,
  input  logic [IDW-1:0]        slv_arid,
  output logic                  slv_rvalid,
  input  logic                  slv_rready,
  output logic [1:0]            slv_rresp,
  output logic [DATAW-1:0]      slv_rdata,
  output logic [IDW-1:0]        slv_rid,
  output logic [NSLV-1:0]       mst_en,
  output logic                  mst_wr,
  output logic [ADDRW-1:0]      mst_addr,
  output logic [XLEN-1:0]       mst_wdata,
  output logic [XLEN/8-1:0]     mst_strb,
  input  logic [NSLV*XLEN-1:0]  mst_rdata,
  input  logic [NSLV-1:0]       mst_ready
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_WDATA = 2'd1;
  localparam logic [1:0] ACCESS     = 2'd2;
  localparam logic [1:0] RESP       = 2'd3;

  localparam int DSCALE = DATAW / XLEN;
  localparam int SW = XLEN / 8;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]       state_r;
  logic             prefer_rd_r;
  logic [IDW-1:0]   id_r;
  logic [TW-1:0]    cnt_r;

  logic [NSLV-1:0]  hit_s;
  logic [XLEN-1:0]  sel_rdata_s;
  logic             ready_hit_s;
  logic             timeout_s;
  logic             finish_s;
  logic [1:0]       fin_resp_s;
  logic [DATAW-1:0] fin_data_s;
  logic             grant_wr_s;
  logic             grant_rd_s;
  int               wlane_s;
  logic             unused_prot;

  assign unused_prot = ^{slv_awprot, slv_arprot};

  function automatic int lane_of(input logic [ADDRW-1:0] a);
    return int'(a[ADDRW-1:2]) % DSCALE;
  endfunction

  // Window compare is done one bit wider so base+size cannot wrap.
  function automatic logic in_win(input logic [ADDRW-1:0] a, input int i);
    logic [ADDRW:0] base;
    logic [ADDRW:0] lim;
    base = {1'b0, SLV_ADDR[i*ADDRW +: ADDRW]};
    lim  = base + {1'b0, SLV_SIZE[i*ADDRW +: ADDRW]};
    return ({1'b0, a} >= base) && ({1'b0, a} < lim);
  endfunction

  // One-hot decode of the held address, lowest matching index wins.
  always_comb begin
    logic found;
    hit_s = '0;
    found = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      hit_s[i] = in_win(mst_addr, i) & ~found;
      found = found | in_win(mst_addr, i);
    end
  end

  // Read word of the enabled slave only; others are masked off.
  always_comb begin
    sel_rdata_s = '0;
    for (int i = 0; i < NSLV; i++) begin
      sel_rdata_s = sel_rdata_s | (mst_rdata[i*XLEN +: XLEN] & {XLEN{mst_en[i]}});
    end
  end

  // Write lane follows awaddr while it is being captured, the held address after.
  always_comb begin
    if (state_r == IDLE) begin
      wlane_s = lane_of(slv_awaddr);
    end else begin
      wlane_s = lane_of(mst_addr);
    end
  end

  assign ready_hit_s = |(mst_en & mst_ready);
  assign timeout_s   = (TIMEOUT != 0) && (int'(cnt_r) == (TIMEOUT - 1));
  assign grant_wr_s  = slv_awvalid & (~slv_arvalid | ~prefer_rd_r);
  assign grant_rd_s  = slv_arvalid & (~slv_awvalid | prefer_rd_r);

  // Decide whether the access ends this cycle and with which response.
  always_comb begin
    finish_s   = 1'b0;
    fin_resp_s = 2'h0;
    fin_data_s = '0;
    if (state_r == ACCESS) begin
      if (mst_en == '0) begin
        finish_s   = ~|hit_s;
        fin_resp_s = 2'h3;
      end else if (ready_hit_s) begin
        finish_s   = 1'b1;
        fin_resp_s = 2'h0;
        fin_data_s = {DSCALE{sel_rdata_s}};
      end else if (timeout_s) begin
        finish_s   = 1'b1;
        fin_resp_s = 2'h2;
      end else begin
        finish_s   = 1'b0;
      end
    end else begin
      finish_s = 1'b0;
    end
  end

  // Main transaction FSM and all registered outputs.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_r     <= IDLE;
      prefer_rd_r <= 1'b0;
      id_r        <= '0;
      cnt_r       <= '0;
      slv_awready <= 1'b0;
      slv_wready  <= 1'b0;
      slv_arready <= 1'b0;
      slv_bvalid  <= 1'b0;
      slv_bresp   <= 2'h0;
      slv_bid     <= '0;
      slv_rvalid  <= 1'b0;
      slv_rresp   <= 2'h0;
      slv_rdata   <= '0;
      slv_rid     <= '0;
      mst_en      <= '0;
      mst_wr      <= 1'b0;
      mst_addr    <= '0;
      mst_wdata   <= '0;
      mst_strb    <= '0;
    end else begin
      slv_awready <= 1'b0;
      slv_wready  <= 1'b0;
      slv_arready <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_wr_s) begin
            slv_awready <= 1'b1;
            mst_addr    <= slv_awaddr;
            id_r        <= slv_awid;
            mst_wr      <= 1'b1;
            prefer_rd_r <= 1'b1;
            if (slv_wvalid) begin
              slv_wready <= 1'b1;
              mst_wdata  <= slv_wdata[wlane_s*XLEN +: XLEN];
              mst_strb   <= slv_wstrb[wlane_s*SW +: SW];
              state_r    <= ACCESS;
            end else begin
              state_r    <= WAIT_WDATA;
            end
          end else if (grant_rd_s) begin
            slv_arready <= 1'b1;
            mst_addr    <= slv_araddr;
            id_r        <= slv_arid;
            mst_wr      <= 1'b0;
            prefer_rd_r <= 1'b0;
            state_r     <= ACCESS;
          end
        end
        WAIT_WDATA: begin
          if (slv_wvalid) begin
            slv_wready <= 1'b1;
            mst_wdata  <= slv_wdata[wlane_s*XLEN +: XLEN];
            mst_strb   <= slv_wstrb[wlane_s*SW +: SW];
            state_r    <= ACCESS;
          end
        end
        ACCESS: begin
          if (finish_s) begin
            mst_en  <= '0;
            state_r <= RESP;
            if (mst_wr) begin
              slv_bvalid <= 1'b1;
              slv_bresp  <= fin_resp_s;
              slv_bid    <= id_r;
            end else begin
              slv_rvalid <= 1'b1;
              slv_rresp  <= fin_resp_s;
              slv_rid    <= id_r;
              slv_rdata  <= fin_data_s;
            end
          end else if (mst_en == '0) begin
            // First ACCESS cycle: launch the enable and restart the timeout count.
            mst_en <= hit_s;
            cnt_r  <= '0;
          end else begin
            cnt_r  <= cnt_r + TW'(1);
          end
        end
        RESP: begin
          if (mst_wr ? slv_bready : slv_rready) begin
            slv_bvalid <= 1'b0;
            slv_rvalid <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_friscv_axil_apb_bridge.sv
// Directed bench: transaction-level model of decode/lane/response rules checked
// against the bridge every cycle, plus hand-computed literal expectations.
module tb_friscv_axil_apb_bridge;

  localparam int TO = 8;

  logic         aclk = 1'b0;
  logic         arst = 1'b0;
  logic         slv_awvalid = 1'b0, slv_awready;
  logic [15:0]  slv_awaddr = '0, slv_awid = '0;
  logic [2:0]   slv_awprot = '0, slv_arprot = '0;
  logic         slv_wvalid = 1'b0, slv_wready;
  logic [127:0] slv_wdata = '0;
  logic [15:0]  slv_wstrb = '0;
  logic         slv_bvalid, slv_bready = 1'b1;
  logic [1:0]   slv_bresp, slv_rresp;
  logic [15:0]  slv_bid, slv_rid;
  logic         slv_arvalid = 1'b0, slv_arready;
  logic [15:0]  slv_araddr = '0, slv_arid = '0;
  logic         slv_rvalid, slv_rready = 1'b1;
  logic [127:0] slv_rdata;
  logic [3:0]   mst_en;
  logic         mst_wr;
  logic [15:0]  mst_addr;
  logic [31:0]  mst_wdata;
  logic [3:0]   mst_strb;
  logic [127:0] mst_rdata;
  logic [3:0]   mst_ready = '0;

  friscv_axil_apb_bridge #(.TIMEOUT(TO)) dut (
    .aclk(aclk), .arst(arst),
    .slv_awvalid(slv_awvalid), .slv_awready(slv_awready), .slv_awaddr(slv_awaddr),
    .slv_awprot(slv_awprot), .slv_awid(slv_awid),
    .slv_wvalid(slv_wvalid), .slv_wready(slv_wready), .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb),
    .slv_bvalid(slv_bvalid), .slv_bready(slv_bready), .slv_bresp(slv_bresp), .slv_bid(slv_bid),
    .slv_arvalid(slv_arvalid), .slv_arready(slv_arready), .slv_araddr(slv_araddr),
    .slv_arprot(slv_arprot), .slv_arid(slv_arid),
    .slv_rvalid(slv_rvalid), .slv_rready(slv_rready), .slv_rresp(slv_rresp),
    .slv_rdata(slv_rdata), .slv_rid(slv_rid),
    .mst_en(mst_en), .mst_wr(mst_wr), .mst_addr(mst_addr), .mst_wdata(mst_wdata),
    .mst_strb(mst_strb), .mst_rdata(mst_rdata), .mst_ready(mst_ready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    bit           wr;
    logic [15:0]  addr;
    logic [15:0]  id;
    int           sel;
    logic [31:0]  wd;
    logic [3:0]   st;
    logic [1:0]   resp;
    logic [127:0] rd;
    int           en_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          base_t[4] = '{0, 16, 32, 48};
  int          size_t[4] = '{16, 16, 16, 16};
  logic [31:0] word_t[4] = '{32'h12345678, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
  int          slv_wait[4] = '{0, 0, -1, -1};
  int          checks = 0;
  int          failures = 0;
  bit          last_wr = 1'b0;
  bit          noise = 1'b0;
  int          en_seen = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected outcome of one transaction from the window table and slave behaviour.
  function automatic exp_t model(input bit wr, input logic [15:0] addr, input logic [15:0] id,
                                 input logic [127:0] wdata, input logic [15:0] wstrb);
    exp_t e;
    int lane;
    e.wr = wr; e.addr = addr; e.id = id; e.sel = -1;
    for (int i = 3; i >= 0; i--)
      if (int'(addr) >= base_t[i] && int'(addr) < base_t[i] + size_t[i]) e.sel = i;
    lane = (int'(addr) / 4) % 4;
    e.wd = wdata[lane*32 +: 32];
    e.st = wstrb[lane*4 +: 4];
    if (e.sel < 0) begin
      e.resp = 2'h3; e.rd = '0; e.en_cyc = 0;
    end else if (slv_wait[e.sel] < 0 || slv_wait[e.sel] + 1 > TO) begin
      e.resp = 2'h2; e.rd = '0; e.en_cyc = TO;
    end else begin
      e.resp = 2'h0; e.rd = {4{word_t[e.sel]}}; e.en_cyc = slv_wait[e.sel] + 1;
    end
    return e;
  endfunction

  initial mst_rdata = {word_t[3], word_t[2], word_t[1], word_t[0]};

  // Peripheral responder: selected slave answers after its wait count; optional noise on others.
  initial begin
    int en_cyc;
    logic [3:0] rb;
    en_cyc = 0;
    forever begin
      @(posedge aclk); #1;
      if (mst_en != 4'd0) en_cyc++; else en_cyc = 0;
      rb = 4'd0;
      for (int i = 0; i < 4; i++) begin
        if (mst_en[i] && slv_wait[i] >= 0 && en_cyc == slv_wait[i] + 1) rb[i] = 1'b1;
        else if (!mst_en[i] && noise) rb[i] = 1'b1;
      end
      mst_ready = rb;
    end
  end

  // Compare process: APB side and response channels against the head expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      if (arst) begin
        en_seen = 0;
      end else begin
        if (mst_en != 4'd0) begin
          if (exp_q.size() == 0) begin
            chk("en_unexpected", mst_en, 4'd0);
          end else begin
            e = exp_q[0];
            chk("mst_en", mst_en, (e.sel < 0) ? 4'd0 : (4'd1 << e.sel));
            chk("mst_addr", mst_addr, e.addr);
            chk("mst_wr", mst_wr, e.wr);
            if (e.wr) begin
              chk("mst_wdata", mst_wdata, e.wd);
              chk("mst_strb", mst_strb, e.st);
            end
            en_seen++;
          end
        end
        if (slv_bvalid || slv_rvalid) begin
          if (exp_q.size() == 0) begin
            chk("resp_unexpected", {slv_bvalid, slv_rvalid}, 2'b00);
          end else begin
            e = exp_q[0];
            chk("resp_kind", {slv_bvalid, slv_rvalid}, {e.wr, !e.wr});
            if (e.wr) begin
              chk("bresp", slv_bresp, e.resp);
              chk("bid", slv_bid, e.id);
            end else begin
              chk("rresp", slv_rresp, e.resp);
              chk("rid", slv_rid, e.id);
              chk("rdata", slv_rdata, e.rd);
            end
            if ((slv_bvalid && slv_bready) || (slv_rvalid && slv_rready)) begin
              chk("en_cycles", en_seen, e.en_cyc);
              en_seen = 0;
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic send_aw(input logic [15:0] a, input logic [15:0] id);
    int n;
    slv_awaddr = a; slv_awid = id; slv_awvalid = 1'b1; n = 0;
    do begin @(negedge aclk); n++; end while (!slv_awready && n < 300);
    chk("aw_handshake", slv_awready, 1'b1);
    @(posedge aclk); #1; slv_awvalid = 1'b0;
  endtask

  task automatic send_w(input int dly, input logic [127:0] d, input logic [15:0] s);
    int n;
    for (int i = 0; i < dly; i++) begin
      @(negedge aclk); chk("wready_early", slv_wready, 1'b0);
      @(posedge aclk); #1;
    end
    slv_wdata = d; slv_wstrb = s; slv_wvalid = 1'b1; n = 0;
    do begin @(negedge aclk); n++; end while (!slv_wready && n < 300);
    chk("w_handshake", slv_wready, 1'b1);
    @(posedge aclk); #1; slv_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [15:0] a, input logic [15:0] id);
    int n;
    slv_araddr = a; slv_arid = id; slv_arvalid = 1'b1; n = 0;
    do begin @(negedge aclk); n++; end while (!slv_arready && n < 300);
    chk("ar_handshake", slv_arready, 1'b1);
    @(posedge aclk); #1; slv_arvalid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(posedge aclk); #1; n++; end
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] id, input logic [127:0] d,
                          input logic [15:0] s, input int dly);
    exp_q.push_back(model(1'b1, a, id, d, s));
    last_wr = 1'b1;
    fork
      send_aw(a, id);
      send_w(dly, d, s);
    join
    wait_empty();
  endtask

  task automatic do_read(input logic [15:0] a, input logic [15:0] id);
    exp_q.push_back(model(1'b0, a, id, '0, '0));
    last_wr = 1'b0;
    send_ar(a, id);
    wait_empty();
  endtask

  // Both channels presented together; the side not served last goes first.
  task automatic do_arb(input logic [15:0] wa, input logic [15:0] ra);
    exp_t ew, er;
    ew = model(1'b1, wa, 16'h0C01, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 16'hFFFF);
    er = model(1'b0, ra, 16'h0C02, '0, '0);
    if (!last_wr) begin
      exp_q.push_back(ew); exp_q.push_back(er); last_wr = 1'b0;
    end else begin
      exp_q.push_back(er); exp_q.push_back(ew); last_wr = 1'b1;
    end
    fork
      send_aw(wa, 16'h0C01);
      send_w(0, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 16'hFFFF);
      send_ar(ra, 16'h0C02);
    join
    wait_empty();
  endtask

  initial begin
    exp_t e;
    logic [127:0] wd;
    int n;

    #2 arst = 1'b1;
    #1;
    chk("rst_readies", {slv_awready, slv_wready, slv_arready, slv_bvalid, slv_rvalid}, 5'd0);
    chk("rst_mst", {mst_en, mst_wr, mst_addr, mst_wdata, mst_strb}, 57'd0);
    chk("rst_resp", {slv_bresp, slv_rresp, slv_bid, slv_rid}, 36'd0);
    chk("rst_rdata", slv_rdata, 128'd0);
    repeat (3) @(posedge aclk);
    #1 arst = 1'b0;
    @(posedge aclk); #1;

    // Lane-1 write to slave 1 with the fixed 3-cycle latency.
    wd = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111};
    e = model(1'b1, 16'h0014, 16'h00A1, wd, 16'h00F0);
    chk("model_wr_lane", {e.wd, e.st}, {32'hDEADBEEF, 4'hF});
    exp_q.push_back(e); last_wr = 1'b1;
    fork
      send_aw(16'h0014, 16'h00A1);
      send_w(0, wd, 16'h00F0);
      for (int k = 0; k < 4; k++) begin
        @(negedge aclk);
        chk("wr_latency_bvalid", slv_bvalid, (k == 3));
        if (k == 2) chk("wr_lit_mst", {mst_en, mst_wdata, mst_strb}, {4'b0010, 32'hDEADBEEF, 4'hF});
        if (k == 3) chk("wr_lit_b", {slv_bresp, slv_bid}, {2'h0, 16'h00A1});
      end
    join
    wait_empty();

    // Slave 0 read with 5 wait cycles, noise on other readies and rready stalled.
    slv_wait[0] = 5; noise = 1'b1; slv_rready = 1'b0;
    e = model(1'b0, 16'h0008, 16'h00B2, '0, '0);
    chk("model_rd", {e.rd, 8'(e.en_cyc)}, {{4{32'h12345678}}, 8'd6});
    exp_q.push_back(e); last_wr = 1'b0;
    fork
      send_ar(16'h0008, 16'h00B2);
      begin
        n = 0;
        while (!slv_rvalid && n < 100) begin @(negedge aclk); n++; end
        repeat (3) @(negedge aclk);
        chk("rd_lit", {slv_rvalid, slv_rresp, slv_rid}, {1'b1, 2'h0, 16'h00B2});
        chk("rd_lit_data", slv_rdata, {4{32'h12345678}});
        @(posedge aclk); #1 slv_rready = 1'b1;
      end
    join
    wait_empty();
    noise = 1'b0;

    // Out-of-window accesses.
    e = model(1'b1, 16'hFF00, 16'h00C3, '0, '0);
    chk("model_misroute", {e.resp, 8'(e.en_cyc)}, {2'h3, 8'd0});
    do_write(16'hFF00, 16'h00C3, wd, 16'hFFFF, 0);
    do_read(16'hFF00, 16'h00C4);

    // Arbitration: write wins with pointer at write, read wins after a lone write.
    do_arb(16'h001C, 16'h0004);
    do_write(16'h0018, 16'h00D1, wd, 16'h0F00, 0);
    do_arb(16'h0010, 16'h0000);

    // Timeout on a silent slave, then a normal access.
    e = model(1'b0, 16'h0020, 16'h00E1, '0, '0);
    chk("model_timeout", {e.resp, 8'(e.en_cyc), e.rd}, {2'h2, 8'd8, 128'd0});
    do_read(16'h0020, 16'h00E1);
    do_write(16'h0028, 16'h00E2, wd, 16'h0F0F, 0);
    do_read(16'h0010, 16'h00E3);

    // W arrives 3 cycles after AW.
    do_write(16'h000C, 16'h00F1, {32'hCAFEF00D, 32'h0, 32'h0, 32'h0}, 16'hF000, 3);

    // Reset during ACCESS, then a fresh transaction.
    exp_q.push_back(model(1'b1, 16'h0030, 16'h0099, wd, 16'hFFFF));
    fork
      send_aw(16'h0030, 16'h0099);
      send_w(0, wd, 16'hFFFF);
    join
    n = 0;
    while (mst_en == 4'd0 && n < 50) begin @(posedge aclk); #1; n++; end
    chk("rst_mid_en_before", mst_en, 4'b1000);
    repeat (2) @(posedge aclk);
    #3 arst = 1'b1;
    #1;
    chk("rst_mid_outputs", {mst_en, slv_bvalid, slv_rvalid, slv_awready, slv_wready}, 8'd0);
    exp_q.delete(); last_wr = 1'b0;
    @(posedge aclk); #1 arst = 1'b0;
    @(posedge aclk); #1;
    slv_wait[3] = 2;
    do_write(16'h0034, 16'h009A, wd, 16'h00F0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
